// File: rtl/intr_ctrl.sv
// Platform interrupt controller: level gateways, priority arbitration, claim/complete register port.
// Latency: request -> e_intr_o 2 cycles; register access -> ready_o/rdata_o 1 cycle.
// Backpressure: none; every access completes in the following cycle, back-to-back accepted.
module intr_ctrl #(
  parameter int NUM_SRC    = 8,
  parameter int PRIO_WIDTH = 3
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NUM_SRC-1:0] src_i,
  input  logic               req_i,
  input  logic               we_i,
  input  logic [31:0]        addr_i,
  input  logic [31:0]        wdata_i,
  output logic [31:0]        rdata_o,
  output logic               ready_o,
  output logic               e_intr_o
);

  // Word addresses (byte address bits [11:2])
  localparam logic [9:0] W_PENDING = 10'h020;
  localparam logic [9:0] W_ENABLE  = 10'h040;
  localparam logic [9:0] W_THRESH  = 10'h080;
  localparam logic [9:0] W_CLAIM   = 10'h081;

  typedef enum logic [1:0] {GW_IDLE, GW_PEND, GW_INSV} gw_t;

  gw_t                   gw_q [NUM_SRC];
  gw_t                   gw_d [NUM_SRC];
  logic [PRIO_WIDTH-1:0] prio_q [NUM_SRC];
  logic [NUM_SRC-1:0]    enable_q;
  logic [PRIO_WIDTH-1:0] thresh_q;
  logic [NUM_SRC-1:0]    pend_vec;
  logic [4:0]            best_id;
  logic [PRIO_WIDTH-1:0] best_prio;
  logic [9:0]            word;
  logic                  rd_acc, wr_acc, claim_fire, cmpl_hit;
  logic [4:0]            cmpl_id;
  logic [31:0]           rd_val;
  logic [31:0]           rdata_q;
  logic                  ready_q, e_intr_q;
  logic                  unused_bits;

  assign word        = addr_i[11:2];
  assign rd_acc      = req_i && !we_i;
  assign wr_acc      = req_i && we_i;
  assign claim_fire  = rd_acc && (word == W_CLAIM) && (best_id != 5'd0);
  assign cmpl_hit    = wr_acc && (word == W_CLAIM);
  assign cmpl_id     = wdata_i[4:0];
  assign unused_bits = ^{addr_i, wdata_i};

  // Pending vector straight from the gateway states
  always_comb begin
    pend_vec = '0;
    for (int i = 0; i < NUM_SRC; i++) pend_vec[i] = (gw_q[i] == GW_PEND);
  end

  // Arbitration: strict '>' keeps the lowest index on ties and excludes prio 0
  always_comb begin
    best_id   = 5'd0;
    best_prio = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (pend_vec[i] && enable_q[i] && (prio_q[i] > best_prio)) begin
        best_prio = prio_q[i];
        best_id   = 5'(i + 1);
      end
    end
  end

  // Gateway next state; src_i is only looked at while IDLE
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      gw_d[i] = gw_q[i];
      case (gw_q[i])
        GW_IDLE: if (src_i[i]) gw_d[i] = GW_PEND;
        GW_PEND: if (claim_fire && (best_id == 5'(i + 1))) gw_d[i] = GW_INSV;
        GW_INSV: if (cmpl_hit && (cmpl_id == 5'(i + 1))) gw_d[i] = GW_IDLE;
        default: gw_d[i] = GW_IDLE;
      endcase
    end
  end

  // Gateway state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_SRC; i++) gw_q[i] <= GW_IDLE;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) gw_q[i] <= gw_d[i];
    end
  end

  // Configuration register writes
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_SRC; i++) prio_q[i] <= '0;
      enable_q <= '0;
      thresh_q <= '0;
    end else if (wr_acc) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (word == 10'(i)) prio_q[i] <= wdata_i[PRIO_WIDTH-1:0];
      end
      if (word == W_ENABLE) enable_q <= wdata_i[NUM_SRC-1:0];
      if (word == W_THRESH) thresh_q <= wdata_i[PRIO_WIDTH-1:0];
    end
  end

  // Read mux; unmapped words read zero
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (word == 10'(i)) rd_val[PRIO_WIDTH-1:0] = prio_q[i];
    end
    case (word)
      W_PENDING: rd_val[NUM_SRC-1:0]    = pend_vec;
      W_ENABLE:  rd_val[NUM_SRC-1:0]    = enable_q;
      W_THRESH:  rd_val[PRIO_WIDTH-1:0] = thresh_q;
      W_CLAIM:   rd_val[4:0]            = best_id;
      default:   ;
    endcase
  end

  // Response and interrupt output registers; rdata is forced to 0 outside a read response
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q  <= '0;
      ready_q  <= 1'b0;
      e_intr_q <= 1'b0;
    end else begin
      ready_q  <= req_i;
      rdata_q  <= rd_acc ? rd_val : 32'd0;
      e_intr_q <= (best_id != 5'd0) && (best_prio > thresh_q);
    end
  end

  assign rdata_o  = rdata_q;
  assign ready_o  = ready_q;
  assign e_intr_o = e_intr_q;

endmodule

// File: tb/tb_intr_ctrl.sv
// Bench for intr_ctrl: scoreboard on the register port plus inline interrupt-line checks.
// Latency: inputs driven on negedge, outputs sampled on negedge.
// Backpressure: none; accesses complete one cycle after issue.
module tb_intr_ctrl;

  localparam int NUM_SRC    = 8;
  localparam int PRIO_WIDTH = 3;

  logic               clk_i = 1'b0;
  logic               rst_ni;
  logic [NUM_SRC-1:0] src_i;
  logic               req_i, we_i;
  logic [31:0]        addr_i, wdata_i;
  logic [31:0]        rdata_o;
  logic               ready_o, e_intr_o;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] dat;
  } exp_t;

  exp_t sb [$];
  int   vectors     = 0;
  int   miscompares = 0;

  intr_ctrl #(.NUM_SRC(NUM_SRC), .PRIO_WIDTH(PRIO_WIDTH)) dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .src_i   (src_i),
    .req_i   (req_i),
    .we_i    (we_i),
    .addr_i  (addr_i),
    .wdata_i (wdata_i),
    .rdata_o (rdata_o),
    .ready_o (ready_o),
    .e_intr_o(e_intr_o)
  );

  always #5 clk_i = ~clk_i;

  // Response monitor: every ready_o pops one expectation from the scoreboard
  always @(negedge clk_i) begin
    exp_t e;
    if (ready_o === 1'b1) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL spurious_ready: ready_o=1 with no access outstanding");
      end else begin
        e = sb.pop_front();
        if (rdata_o !== e.dat) begin
          miscompares++;
          $display("FAIL rdata@%h: got %h expected %h", e.addr, rdata_o, e.dat);
        end
      end
    end else if (rst_ni === 1'b1 && rdata_o !== 32'd0) begin
      vectors++;
      miscompares++;
      $display("FAIL idle_rdata: got %h expected 0", rdata_o);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // All bus tasks start and end on a negedge; the access commits at the posedge in between
  task automatic rd(input logic [31:0] a, input logic [31:0] exp);
    exp_t e;
    req_i = 1'b1; we_i = 1'b0; addr_i = a; wdata_i = '0;
    e.addr = a; e.dat = exp; sb.push_back(e);
    @(negedge clk_i);
    req_i = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    req_i = 1'b1; we_i = 1'b1; addr_i = a; wdata_i = d;
    e.addr = a; e.dat = 32'd0; sb.push_back(e);
    @(negedge clk_i);
    req_i = 1'b0; we_i = 1'b0;
  endtask

  task automatic pulse(input int n);
    src_i[n] = 1'b1;
    @(negedge clk_i);
    src_i[n] = 1'b0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; src_i = '0; req_i = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0;
    repeat (2) @(negedge clk_i);
    vectors++;
    if ({e_intr_o, ready_o, rdata_o} !== 34'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: e_intr=%b ready=%b rdata=%h expected 0", e_intr_o, ready_o, rdata_o);
    end
    rst_ni = 1'b1;
    @(negedge clk_i);
    rd(32'h080, 32'h0);
    rd(32'h100, 32'h0);
    rd(32'h200, 32'h0);
    rd(32'h008, 32'h0);
    rd(32'h204, 32'h0);
  endtask

  task automatic test_single();
    wr(32'h008, 3);
    wr(32'h100, 32'h04);
    wr(32'h200, 0);
    pulse(2);
    vectors++;
    if (e_intr_o !== 1'b0) begin
      miscompares++; $display("FAIL single_early: e_intr=%b expected 0", e_intr_o);
    end
    rd(32'h080, 32'h04);
    vectors++;
    if (e_intr_o !== 1'b1) begin
      miscompares++; $display("FAIL single_rise: e_intr=%b expected 1", e_intr_o);
    end
    rd(32'h204, 3);
    vectors++;
    if (e_intr_o !== 1'b1) begin
      miscompares++; $display("FAIL single_claim_hold: e_intr=%b expected 1", e_intr_o);
    end
    @(negedge clk_i);
    vectors++;
    if (e_intr_o !== 1'b0) begin
      miscompares++; $display("FAIL single_claim_drop: e_intr=%b expected 0", e_intr_o);
    end
    wr(32'h204, 3);
    rd(32'h080, 32'h0);
    vectors++;
    if (e_intr_o !== 1'b0) begin
      miscompares++; $display("FAIL single_after_complete: e_intr=%b expected 0", e_intr_o);
    end
  endtask

  task automatic test_priority_tie();
    wr(32'h004, 2);
    wr(32'h010, 5);
    wr(32'h018, 5);
    wr(32'h100, 32'h52);
    src_i = 8'h52;
    repeat (2) @(negedge clk_i);
    vectors++;
    if (e_intr_o !== 1'b1) begin
      miscompares++; $display("FAIL tie_rise: e_intr=%b expected 1", e_intr_o);
    end
    rd(32'h204, 5);
    @(negedge clk_i);
    vectors++;
    if (e_intr_o !== 1'b1) begin
      miscompares++; $display("FAIL tie_after_claim1: e_intr=%b expected 1", e_intr_o);
    end
    rd(32'h204, 7);
    @(negedge clk_i);
    vectors++;
    if (e_intr_o !== 1'b1) begin
      miscompares++; $display("FAIL tie_after_claim2: e_intr=%b expected 1", e_intr_o);
    end
    rd(32'h204, 2);
    @(negedge clk_i);
    vectors++;
    if (e_intr_o !== 1'b0) begin
      miscompares++; $display("FAIL tie_after_claim3: e_intr=%b expected 0", e_intr_o);
    end
    rd(32'h204, 0);
    src_i = '0;
    wr(32'h204, 2);
    wr(32'h204, 5);
    wr(32'h204, 7);
    rd(32'h080, 32'h0);
  endtask

  task automatic test_threshold_enable();
    wr(32'h000, 2);
    wr(32'h200, 2);
    wr(32'h100, 32'h01);
    pulse(0);
    @(negedge clk_i);
    vectors++;
    if (e_intr_o !== 1'b0) begin
      miscompares++; $display("FAIL thresh_equal: e_intr=%b expected 0", e_intr_o);
    end
    wr(32'h200, 1);
    @(negedge clk_i);
    vectors++;
    if (e_intr_o !== 1'b1) begin
      miscompares++; $display("FAIL thresh_below: e_intr=%b expected 1", e_intr_o);
    end
    wr(32'h100, 32'h00);
    @(negedge clk_i);
    vectors++;
    if (e_intr_o !== 1'b0) begin
      miscompares++; $display("FAIL enable_off: e_intr=%b expected 0", e_intr_o);
    end
    rd(32'h080, 32'h01);
    wr(32'h100, 32'h01);
    wr(32'h200, 2);
    rd(32'h204, 1);
    wr(32'h204, 1);
    wr(32'h200, 0);
    rd(32'h080, 32'h0);
  endtask

  task automatic test_gateway_mask();
    wr(32'h00C, 4);
    wr(32'h100, 32'h08);
    src_i[3] = 1'b1;
    repeat (2) @(negedge clk_i);
    rd(32'h204, 4);
    repeat (3) @(negedge clk_i);
    rd(32'h080, 32'h00);
    wr(32'h204, 4);
    rd(32'h080, 32'h00);
    rd(32'h080, 32'h08);
    src_i[3] = 1'b0;
    rd(32'h204, 4);
    wr(32'h204, 4);
    rd(32'h080, 32'h00);
  endtask

  task automatic test_invalid_complete();
    wr(32'h100, 32'h09);
    src_i[0] = 1'b1; src_i[3] = 1'b1;
    @(negedge clk_i);
    src_i = '0;
    rd(32'h204, 4);
    src_i[3] = 1'b1;
    wr(32'h204, 0);
    wr(32'h204, 31);
    wr(32'h204, 1);
    rd(32'h080, 32'h01);
    src_i[3] = 1'b0;
    rd(32'h204, 1);
    wr(32'h204, 4);
    wr(32'h204, 1);
    rd(32'h080, 32'h00);
  endtask

  task automatic test_back_to_back();
    logic        we_a [8];
    logic [31:0] ad [8];
    logic [31:0] wd [8];
    logic [31:0] ex [8];
    exp_t        e;
    we_a = '{1, 0, 1, 0, 0, 0, 1, 0};
    ad   = '{32'h01C, 32'h01C, 32'h100, 32'h100, 32'h300, 32'h020, 32'h01C, 32'h01C};
    wd   = '{6, 0, 32'hA5, 0, 0, 0, 32'hFFFF_FFFF, 0};
    ex   = '{0, 6, 0, 32'hA5, 0, 0, 0, 7};
    for (int i = 0; i < 8; i++) begin
      req_i = 1'b1; we_i = we_a[i]; addr_i = ad[i]; wdata_i = wd[i];
      e.addr = ad[i]; e.dat = ex[i]; sb.push_back(e);
      @(negedge clk_i);
    end
    req_i = 1'b0; we_i = 1'b0;
    rd(32'h200, 0);
    rd(32'h084, 0);
  endtask

  task automatic test_reset_mid_service();
    wr(32'h014, 4);
    wr(32'h008, 3);
    wr(32'h100, 32'h24);
    src_i[2] = 1'b1; src_i[5] = 1'b1;
    @(negedge clk_i);
    src_i = '0;
    rd(32'h204, 6);
    @(negedge clk_i);
    vectors++;
    if (e_intr_o !== 1'b1) begin
      miscompares++; $display("FAIL mid_before_reset: e_intr=%b expected 1", e_intr_o);
    end
    #2 rst_ni = 1'b0;
    #1;
    vectors++;
    if (e_intr_o !== 1'b0) begin
      miscompares++; $display("FAIL async_reset_drop: e_intr=%b expected 0", e_intr_o);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    rd(32'h080, 32'h0);
    rd(32'h014, 32'h0);
    rd(32'h100, 32'h0);
    vectors++;
    if (e_intr_o !== 1'b0) begin
      miscompares++; $display("FAIL after_reset_intr: e_intr=%b expected 0", e_intr_o);
    end
    wr(32'h014, 4);
    wr(32'h100, 32'h20);
    pulse(5);
    rd(32'h080, 32'h20);
    rd(32'h204, 6);
    wr(32'h204, 6);
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority_tie();
    test_threshold_enable();
    test_gateway_mask();
    test_invalid_complete();
    test_back_to_back();
    test_reset_mid_service();
    repeat (2) @(negedge clk_i);
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL missing_ready: %0d responses outstanding, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/intr_ctrl.md
# intr_ctrl

Platform interrupt controller that drives the CPU's external-interrupt input (`e_intr`) seen by the CSR register file. It collects level-sensitive requests from peripherals, holds them pending, and raises `e_intr_o` for the highest-priority enabled request above a programmable threshold. A claim/complete handshake over a simple memory-mapped register port lets the trap handler identify and retire the source.

## Interface
- `NUM_SRC`, 8: number of interrupt sources, 1..31. Source n has ID n+1; ID 0 means "none".
- `PRIO_WIDTH`, 3: width of each source priority. Priority 0 never interrupts.
- `clk_i` in 1: single clock.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `src_i` in NUM_SRC: level interrupt requests, synchronous to `clk_i`.
- `req_i` in 1: register access strobe, one cycle per access.
- `we_i` in 1: 1 = write, 0 = read.
- `addr_i` in 32: byte address. Only bits [11:2] are decoded.
- `wdata_i` in 32: write data.
- `rdata_o` out 32: read data, valid while `ready_o` = 1.
- `ready_o` out 1: access done, one-cycle pulse.
- `e_intr_o` out 1: external interrupt request to the CPU, level.

## Operation
- Register map. Unmapped reads return 0; unmapped writes are ignored.
  - 0x000 + 4n: PRIO[n], RW, bits [PRIO_WIDTH-1:0], upper bits read 0.
  - 0x080: PENDING, RO, bit n = source n pending.
  - 0x100: ENABLE, RW, bits [NUM_SRC-1:0].
  - 0x200: THRESHOLD, RW, bits [PRIO_WIDTH-1:0].
  - 0x204: CLAIM (read) / COMPLETE (write).
- Per-source gateway FSM:
  - IDLE -> PENDING when `src_i[n]` = 1 at a clock edge.
  - PENDING -> IN_SERVICE when this source is claimed.
  - IN_SERVICE -> IDLE on a COMPLETE write of ID n+1.
  - In PENDING and IN_SERVICE, `src_i[n]` is ignored; no double counting.
  - ENABLE does not gate the gateway: a disabled source may pend, but it does not arbitrate.
- Arbitration (combinational over the registered state):
  - Candidates are sources with pending & enable & prio > 0.
  - Winner is the highest prio; ties go to the lowest index.
  - `best_id` = winner n+1, or 0 if there are no candidates.
- `e_intr_o` (registered): 1 iff `best_id` ≠ 0 and prio(winner) > THRESHOLD.
- CLAIM read:
  - Returns `best_id` regardless of THRESHOLD, zero-extended.
  - If nonzero, that source moves to IN_SERVICE.
  - Reading 0 has no side effects.
- COMPLETE write:
  - Takes `wdata_i[4:0]` as the ID.
  - Only an ID in 1..NUM_SRC whose source is IN_SERVICE takes effect; any other value is ignored.
- Multiple sources may be IN_SERVICE at once (nested handlers).
- Reset values:
  - All gateways IDLE; PRIO, ENABLE and THRESHOLD = 0.
  - `e_intr_o` = 0, `ready_o` = 0, `rdata_o` = 0.

## Timing
- `src_i[n]` high at edge k: PENDING is visible after edge k. `e_intr_o` rises after edge k+1 (2-cycle latency from the request to `e_intr_o`).
- Bus access:
  - `req_i` sampled at edge k: the write or claim side effect is committed at edge k.
  - `ready_o` = 1 and `rdata_o` are valid after edge k, for one cycle.
  - `rdata_o` returns 0 when `ready_o` = 0.
  - Back-to-back `req_i` every cycle is supported.
- Claim at edge k: the claimed source leaves the candidate set after edge k. `e_intr_o` reflects the next winner, or drops, after edge k+1.
- Same-edge events:
  - Claim and `src_i[n]` rising for the claimed source: it goes to IN_SERVICE.
  - COMPLETE and `src_i[n]` = 1 for that source: it goes to IDLE at edge k and re-pends at edge k+1.
  - PRIO, ENABLE or THRESHOLD writes affect arbitration from the cycle after the write edge; `e_intr_o` follows one edge later.
- Reset asserted mid-operation clears all state asynchronously. `e_intr_o` drops immediately, with no pending or in-service state kept.

## Test plan
- Single source:
  - Setup: PRIO[2] = 3, ENABLE = 0x04, THRESHOLD = 0.
  - `src_i[2]` pulse one cycle -> PENDING = 0x04 and `e_intr_o` = 1 two edges later.
  - CLAIM reads 3 and `e_intr_o` falls.
  - COMPLETE 3 with `src_i` low -> PENDING = 0 and no new `e_intr_o`.
- Priority/tie:
  - Setup: PRIO[1] = 2, PRIO[4] = 5, PRIO[6] = 5; sources 1, 4 and 6 all held high and enabled.
  - Claims return 5, then 7, then 2, then 0.
  - `e_intr_o` stays 1 until the third claim.
- Threshold/enable:
  - PRIO[0] = 2 with THRESHOLD = 2 -> `e_intr_o` = 0 while CLAIM still returns 1.
  - THRESHOLD = 1 -> `e_intr_o` = 1.
  - ENABLE = 0 -> `e_intr_o` = 0 and PENDING bit 0 stays 1.
- Gateway masking: source 3 held high after claim -> no re-pend until COMPLETE 4, then re-pends one edge later.
- Invalid complete: COMPLETE 0, COMPLETE 31, and COMPLETE of a source that is only PENDING -> no state change.
- Reset mid-service: claim source 5, assert `rst_ni` = 0 asynchronously -> `e_intr_o` = 0 immediately; PENDING, PRIO and ENABLE read 0 after release.
